// File: rtl/trees_ping_pong_v2.sv
// trees_ping_pong_v2: decision-forest classifier over ping-pong feature banks; define TREES_PP_PROFILE_EN for cycle_count
module trees_ping_pong_v2 #(
    parameter int N_TREES          = 128,
    parameter int N_NODE_AND_LEAFS = 256,
    parameter int N_FEATURE        = 32,
    parameter int MAX_BURST        = 54,
    parameter int N_CLASSES        = 8,
    parameter int MAX_DEPTH        = 64,
    localparam int TL = $clog2(N_NODE_AND_LEAFS),
    localparam int TI = $clog2(N_TREES),
    localparam int BB = $clog2(MAX_BURST + 1),
    localparam int FA = $clog2(MAX_BURST * N_FEATURE / 2),
    localparam int PA = $clog2((MAX_BURST + 7) / 8),
    localparam int VC = $clog2(N_TREES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          bank_sel,
    input  logic          load_trees,
    input  logic [TL-1:0] n_node,
    input  logic [TI-1:0] n_tree,
    input  logic [63:0]   tree_nodes,
    input  logic          load_features,
    input  logic          load_bank,
    input  logic [31:0]   feature_addr,
    input  logic [63:0]   features2,
    input  logic [BB-1:0] burst_len,
    input  logic [PA-1:0] prediction_addr,
    output logic [63:0]   prediction,
    output logic          busy,
    output logic          done
`ifdef TREES_PP_PROFILE_EN
    ,
    output logic [31:0]   cycle_count
`endif
);
    localparam int CW = N_CLASSES > 1 ? $clog2(N_CLASSES) : 1;
    localparam int DW = $clog2(MAX_DEPTH + 1);
    localparam int FW = MAX_BURST * N_FEATURE / 2;
    localparam int PW = (MAX_BURST + 7) / 8;
    localparam int HF = N_FEATURE / 2;

    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, EVAL, NEXT_TREE, VOTE, WRITE, DONE} state_t;
    state_t state, nstate;

    logic [63:0]   nmem [N_TREES][N_NODE_AND_LEAFS];
    logic [63:0]   fmem [2][FW];
    logic [63:0]   pmem [PW];
    logic [VC-1:0] cnt [N_CLASSES];

    logic          bank_q;
    logic [BB-1:0] burst_q, s_q;
    logic [TI-1:0] t_q;
    logic [TL-1:0] nd_q;
    logic [DW-1:0] dep_q;
    logic [63:0]   nw_q;
    logic [CW-1:0] v_q;
    logic [VC-1:0] best_cnt;
    logic [7:0]    best_cls;

    function automatic logic [31:0] fkey(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    logic [7:0]  fidx, cls;
    logic [31:0] faddr, fval;
    logic [63:0] fword;
    logic        is_leaf, go_left, cls_ok, depth_hit, last_tree, last_cls, last_samp;
    logic        unused;

    assign busy      = state != IDLE && state != DONE;
    assign done      = state == DONE;
    assign fidx      = nw_q[39:32];
    assign cls       = nw_q[7:0];
    assign faddr     = 32'(s_q) * 32'(HF) + 32'(fidx >> 1);
    assign fword     = fmem[bank_q][faddr[FA-1:0]];
    assign fval      = fidx[0] ? fword[63:32] : fword[31:0];
    assign go_left   = fkey(fval) < fkey(nw_q[31:0]);
    assign is_leaf   = nw_q[63];
    assign cls_ok    = {1'b0, cls} < 9'(N_CLASSES);
    assign depth_hit = dep_q == DW'(MAX_DEPTH - 1);
    assign last_tree = t_q == TI'(N_TREES - 1);
    assign last_cls  = v_q == CW'(N_CLASSES - 1);
    assign last_samp = s_q + 1'b1 == burst_q;
    assign unused    = ^{feature_addr, nw_q};

    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= nstate;

    always_comb begin
        nstate = state;
        case (state)
            IDLE:      nstate = start ? CLEAR : IDLE;
            CLEAR:     nstate = burst_q == '0 ? DONE : FETCH;
            FETCH:     nstate = EVAL;
            EVAL:      nstate = (is_leaf || depth_hit) ? NEXT_TREE : FETCH;
            NEXT_TREE: nstate = last_tree ? VOTE : FETCH;
            VOTE:      nstate = last_cls ? WRITE : VOTE;
            WRITE:     nstate = last_samp ? DONE : CLEAR;
            default:   nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_q   <= 1'b0;
            burst_q  <= '0;
            s_q      <= '0;
            t_q      <= '0;
            nd_q     <= '0;
            dep_q    <= '0;
            v_q      <= '0;
            best_cnt <= '0;
            best_cls <= '0;
            for (int i = 0; i < N_CLASSES; i++) cnt[i] <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    bank_q  <= bank_sel;
                    burst_q <= burst_len > BB'(MAX_BURST) ? BB'(MAX_BURST) : burst_len;
                    s_q     <= '0;
                end
                CLEAR: begin
                    t_q   <= '0;
                    nd_q  <= '0;
                    dep_q <= '0;
                    for (int i = 0; i < N_CLASSES; i++) cnt[i] <= '0;
                end
                EVAL: if (!is_leaf) begin
                    nd_q  <= go_left ? nd_q + 1'b1 : nw_q[40 +: TL];
                    dep_q <= dep_q + 1'b1;
                end else if (cls_ok) begin
                    cnt[cls[CW-1:0]] <= cnt[cls[CW-1:0]] + 1'b1;
                end
                NEXT_TREE: begin
                    t_q      <= t_q + 1'b1;
                    nd_q     <= '0;
                    dep_q    <= '0;
                    v_q      <= '0;
                    best_cnt <= '0;
                    best_cls <= '0;
                end
                // strict compare keeps the lowest class on ties and class 0 when all counts are zero
                VOTE: begin
                    v_q <= v_q + 1'b1;
                    if (cnt[v_q] > best_cnt) begin
                        best_cnt <= cnt[v_q];
                        best_cls <= 8'(v_q);
                    end
                end
                WRITE: s_q <= s_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == FETCH) nw_q <= nmem[t_q][nd_q];
        if (load_trees && !busy) nmem[n_tree][n_node] <= tree_nodes;
    end

    // the bank being classified is write-protected only while a run is active
    always_ff @(posedge clk)
        if (load_features && 32'(feature_addr[FA-1:0]) < 32'(FW) && !(busy && load_bank == bank_q))
            fmem[load_bank][feature_addr[FA-1:0]] <= features2;

    always_ff @(posedge clk)
        if (state == WRITE) begin
            if (s_q[2:0] == 3'd0) pmem[PA'(s_q >> 3)] <= {56'd0, best_cls};
            else pmem[PA'(s_q >> 3)][{s_q[2:0], 3'b000} +: 8] <= best_cls;
        end

    always_ff @(posedge clk)
        if (!rst_n) prediction <= '0;
        else prediction <= pmem[prediction_addr];

`ifdef TREES_PP_PROFILE_EN
    always_ff @(posedge clk)
        if (!rst_n || (state == IDLE && start)) cycle_count <= '0;
        else if (busy && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
`endif
endmodule

// File: tb/tb_trees_ping_pong_v2.sv
// tb_trees_ping_pong_v2: directed self-checking bench for trees_ping_pong_v2 on a reduced configuration
module tb_trees_ping_pong_v2;
    localparam int NT = 4, NN = 16, NF = 4, MB = 54, NC = 8, MD = 8;
    localparam int TL = $clog2(NN), TI = $clog2(NT), BB = $clog2(MB + 1);
    localparam int PA = $clog2((MB + 7) / 8);
    localparam logic [31:0] F_HALF = 32'h3F00_0000, F_ONE = 32'h3F80_0000, F_MONE = 32'hBF80_0000;
    localparam logic [31:0] F_TWO = 32'h4000_0000, F_MTWO = 32'hC000_0000, F_THREE = 32'h4040_0000;
    localparam logic [31:0] F_NZERO = 32'h8000_0000, F_PINF = 32'h7F80_0000, F_NINF = 32'hFF80_0000;

    logic clk = 0, rst_n = 0, start = 0, bank_sel = 0, load_trees = 0, load_features = 0, load_bank = 0;
    logic [TL-1:0] n_node = '0;
    logic [TI-1:0] n_tree = '0;
    logic [63:0]   tree_nodes = '0, features2 = '0;
    logic [31:0]   feature_addr = '0;
    logic [BB-1:0] burst_len = '0;
    logic [PA-1:0] prediction_addr = '0;
    logic [63:0]   prediction;
    logic          busy, done;
`ifdef TREES_PP_PROFILE_EN
    logic [31:0]   cycle_count;
`endif
    int n_cmp = 0, n_bad = 0, done_cnt = 0, lat = 0, d0 = 0;

    trees_ping_pong_v2 #(.N_TREES(NT), .N_NODE_AND_LEAFS(NN), .N_FEATURE(NF),
                         .MAX_BURST(MB), .N_CLASSES(NC), .MAX_DEPTH(MD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bank_sel(bank_sel), .load_trees(load_trees),
        .n_node(n_node), .n_tree(n_tree), .tree_nodes(tree_nodes), .load_features(load_features),
        .load_bank(load_bank), .feature_addr(feature_addr), .features2(features2),
        .burst_len(burst_len), .prediction_addr(prediction_addr), .prediction(prediction),
        .busy(busy), .done(done)
`ifdef TREES_PP_PROFILE_EN
        , .cycle_count(cycle_count)
`endif
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] leaf(input logic [7:0] c);
        return {1'b1, 55'd0, c};
    endfunction

    function automatic logic [63:0] inode(input logic [31:0] thr, input logic [7:0] f, input logic [15:0] r);
        return {8'd0, r, f, thr};
    endfunction

    function automatic logic [31:0] f3_of(input int s, input bit inv);
        return ((s % 2 == 0) ^ inv) ? F_ONE : F_MONE;
    endfunction

    function automatic logic [63:0] exp_pp(input int w, input bit inv);
        logic [63:0] r = '0;
        for (int b = 0; b < 8; b++) begin
            int s = w * 8 + b;
            if (s < MB) r[b*8 +: 8] = ((s % 2 == 0) ^ inv) ? 8'd2 : 8'd1;
        end
        return r;
    endfunction

    task automatic wr_node(input int t, input int n, input logic [63:0] w);
        @(negedge clk);
        load_trees = 1; n_tree = TI'(t); n_node = TL'(n); tree_nodes = w;
        @(negedge clk);
        load_trees = 0;
    endtask

    task automatic wr_feat(input logic b, input int a, input logic [63:0] w);
        @(negedge clk);
        load_features = 1; load_bank = b; feature_addr = 32'(a); features2 = w;
        @(negedge clk);
        load_features = 0;
    endtask

    task automatic set_trees(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
        wr_node(0, 0, leaf(c0));
        wr_node(1, 0, leaf(c1));
        wr_node(2, 0, leaf(c2));
        wr_node(3, 0, leaf(c3));
    endtask

    task automatic run(input logic b, input int len, input bit poke, input bit ld, input int ld_addr, input logic [63:0] ld_w);
        @(negedge clk);
        start = 1; bank_sel = b; burst_len = BB'(len);
        if (ld) begin
            load_features = 1; load_bank = b; feature_addr = 32'(ld_addr); features2 = ld_w;
        end
        @(negedge clk);
        start = 0; load_features = 0; lat = 1;
        chk("busy_rise", busy, 1);
        while (!done && lat < 5000) begin
            @(negedge clk);
            lat++;
            if (poke) start = (lat == 5);
        end
        start = 0;
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    task automatic rd(input int a, input logic [63:0] exp, input string tag);
        @(negedge clk);
        prediction_addr = PA'(a);
        @(negedge clk);
        chk(tag, prediction, exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pred", prediction, 0);
        rst_n = 1;

        // every tree votes 3, ten samples
        set_trees(3, 3, 3, 3);
        d0 = done_cnt;
        run(0, 10, 0, 0, 0, 0);
        chk("all3_lat", lat, 221);
        rd(0, 64'h0303_0303_0303_0303, "all3_w0");
        rd(1, 64'h0000_0000_0000_0303, "all3_w1");
        chk("all3_done_once", done_cnt, d0 + 1);

        // stump on f0 < 1.0; sample 0 is written in the same cycle as start
        wr_node(0, 0, inode(F_ONE, 0, 2));
        wr_node(0, 1, leaf(1));
        wr_node(0, 2, leaf(2));
        for (int t = 1; t < NT; t++) wr_node(t, 0, leaf(200));
        wr_feat(0, 0, {32'd0, F_THREE});
        wr_feat(0, 2, {32'd0, F_ONE});
        wr_feat(0, 4, {32'd0, F_NZERO});
        wr_feat(0, 6, {32'd0, F_MTWO});
        wr_feat(0, 8, {32'd0, F_TWO});
        run(0, 5, 0, 1, 0, {32'd0, F_HALF});
        chk("stump_lat", lat, 121);
        rd(0, 64'h0000_0002_0101_0201, "stump_w0");

        // vote ties and out-of-range classes
        set_trees(5, 2, 200, 200);
        run(0, 1, 0, 0, 0, 0);
        chk("tie_lat", lat, 23);
        rd(0, 64'h2, "tie_lowest");
        set_trees(5, 2, 5, 200);
        run(0, 1, 0, 0, 0, 0);
        rd(0, 64'h5, "majority");
        set_trees(8, 8, 7, 200);
        run(0, 1, 0, 0, 0, 0);
        rd(0, 64'h7, "class_bound");
        set_trees(200, 200, 200, 200);
        wr_node(0, 0, leaf(200));
        run(0, 1, 0, 0, 0, 0);
        rd(0, 64'h0, "all_abstain");

        // tree 0 loops forever and abstains; tree 1 hits its leaf on the last allowed node
        wr_feat(0, 0, {32'd0, F_HALF});
        wr_node(0, 0, inode(F_NINF, 0, 0));
        for (int n = 0; n < MD - 1; n++) wr_node(1, n, inode(F_PINF, 0, 15));
        wr_node(1, MD - 1, leaf(6));
        run(0, 1, 0, 0, 0, 0);
        chk("depth_lat", lat, 51);
        rd(0, 64'h6, "depth_leaf");

        // empty burst, over-long burst with a start poked mid-run
        set_trees(3, 3, 3, 3);
        d0 = done_cnt;
        run(0, 0, 0, 0, 0, 0);
        chk("zero_lat", lat, 2);
        rd(0, 64'h6, "zero_unchanged");
        run(0, 60, 1, 0, 0, 0);
        chk("clamp_lat", lat, 1189);
        rd(6, 64'h0000_0303_0303_0303, "clamp_w6");
        rd(0, 64'h0303_0303_0303_0303, "clamp_w0");
        chk("clamp_done_cnt", done_cnt, d0 + 2);

        // ping-pong: classify bank 0 while bank 1 is loaded and bank 0 writes are refused
        wr_node(0, 0, inode(32'h0, 3, 2));
        wr_node(0, 1, leaf(1));
        wr_node(0, 2, leaf(2));
        for (int t = 1; t < NT; t++) wr_node(t, 0, leaf(200));
        for (int s = 0; s < MB; s++) wr_feat(0, 2 * s + 1, {f3_of(s, 0), 32'd0});
        fork
            run(0, MB, 0, 0, 0, 0);
            begin
                repeat (4) @(negedge clk);
                for (int s = 0; s < MB; s++) wr_feat(0, 2 * s + 1, {f3_of(s, 1), 32'd0});
                for (int s = 0; s < MB; s++) wr_feat(1, 2 * s + 1, {f3_of(s, 1), 32'd0});
            end
        join
        chk("pp0_lat", lat, 1297);
        for (int w = 0; w < 7; w++) rd(w, exp_pp(w, 0), "pp_bank0");
        run(1, MB, 0, 0, 0, 0);
        for (int w = 0; w < 7; w++) rd(w, exp_pp(w, 1), "pp_bank1");

        // reset in the middle of a run, then rerun
        set_trees(3, 3, 3, 3);
        @(negedge clk);
        start = 1; bank_sel = 0; burst_len = BB'(10);
        @(negedge clk);
        start = 0;
        repeat (30) @(negedge clk);
        d0 = done_cnt;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (300) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        set_trees(4, 4, 4, 4);
        run(0, 3, 0, 0, 0, 0);
        chk("rerun_lat", lat, 67);
        rd(0, 64'h0000_0000_0004_0404, "rerun_w0");
`ifdef TREES_PP_PROFILE_EN
        chk("cycle_count", cycle_count, 66);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
